// File: rtl/dac_pkg.sv
// Shared constants and FSM state type for the DAC sample pacer.
// Imported by the pacer top level and its FIFO.
package dac_pkg;

  localparam int DATA_W     = 16;
  localparam int MIN_PERIOD = 576;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_e;

  function automatic logic [15:0] clamp_period(
    input logic [15:0] p,
    input logic [15:0] mn
  );
    return (p < mn) ? mn : p;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy counter.
// Simultaneous push and pop are both honoured, even when full.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;
  logic [AW:0]       cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign head    = mem_q[rptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/dac_sample_pacer.sv
// Paces buffered samples out to the AD5541 SPI DAC driver as
// tx_data/dv strobes, one per programmable update period.
module dac_sample_pacer #(
  parameter int DATA_W     = dac_pkg::DATA_W,
  parameter int DEPTH      = 16,
  parameter int DV_WIDTH   = 2,
  parameter int MIN_PERIOD = dac_pkg::MIN_PERIOD,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [15:0]       period,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level,
  output logic              overflow,
  output logic              underrun,
  output logic              dv,
  output logic [DATA_W-1:0] tx_data
);

  import dac_pkg::*;

  localparam logic [15:0] MINP = 16'(MIN_PERIOD);
  localparam int WCW = (DV_WIDTH > 1) ? $clog2(DV_WIDTH) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(DV_WIDTH - 1);

  logic              enable_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic [15:0]       per_q;
  logic [15:0]       eff_p;
  logic              rise;
  logic              tick;
  logic              pop;
  logic [DATA_W-1:0] head;
  state_e            state_q;
  logic [WCW-1:0]    wcnt_q;
  logic              dv_q;
  logic [DATA_W-1:0] tx_q;
  logic              ovf_q;
  logic              udr_q;

  assign eff_p = clamp_period(period, MINP);
  assign rise  = enable & ~enable_q;
  assign tick  = enable & enable_q & (cnt_q == per_q - 16'd1);
  assign pop   = tick & (state_q == IDLE) & ~empty;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_en),
    .pop     (pop),
    .wdata   (wr_data),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    unique case (1'b1)
      !enable:     cnt_d = '0;
      rise | tick: cnt_d = '0;
      default:     cnt_d = cnt_q + 16'd1;
    endcase
  end

  // Period is re-sampled only at enable rise and on ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      cnt_q    <= '0;
      per_q    <= MINP;
    end else begin
      enable_q <= enable;
      cnt_q    <= cnt_d;
      if (rise | tick) per_q <= eff_p;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      dv_q    <= 1'b0;
      tx_q    <= '0;
      ovf_q   <= 1'b0;
      udr_q   <= 1'b0;
    end else begin
      ovf_q <= wr_en & full & ~pop;
      udr_q <= tick & (state_q == IDLE) & empty;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_q    <= head;
            dv_q    <= 1'b1;
            wcnt_q  <= '0;
            state_q <= PULSE;
          end
        end
        PULSE: begin
          if (wcnt_q == WLAST) begin
            dv_q    <= 1'b0;
            state_q <= IDLE;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dv       = dv_q;
  assign tx_data  = tx_q;
  assign overflow = ovf_q;
  assign underrun = udr_q;

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer with a queue-based reference model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_dac_sample_pacer;

  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int DVW = 2;
  localparam int unsigned MINP = 576;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [15:0]   period = 16'd1000;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, underrun, dv;
  logic [LW-1:0] level;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  dac_sample_pacer #(
    .DATA_W(DW), .DEPTH(DEPTH), .DV_WIDTH(DVW), .MIN_PERIOD(int'(MINP))
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .underrun(underrun),
    .dv(dv), .tx_data(tx_data)
  );

  typedef struct {
    int unsigned   e;
    logic [DW-1:0] d;
  } strobe_t;

  strobe_t       sq[$];
  int unsigned   uq[$];
  int unsigned   oq[$];
  logic [DW-1:0] fq[$];
  int unsigned   rise_log[$];
  int unsigned   cyc = 0;
  int unsigned   next_tick = 0;
  int unsigned   busy_until = 0;
  bit            en_prev = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int unsigned   ur_count = 0;
  int unsigned   ov_count = 0;
  logic [DW-1:0] cur_data = '0;

  function automatic int unsigned effp(input logic [15:0] p);
    return (32'(p) < MINP) ? MINP : 32'(p);
  endfunction

  // Reference model: ticks derived from absolute cycle numbers
  int unsigned m_pre;
  bit          m_pop;
  strobe_t     m_s;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      fq.delete(); sq.delete(); uq.delete(); oq.delete();
      en_prev = 1'b0;
      busy_until = 0;
    end else begin
      m_pre = fq.size();
      m_pop = 1'b0;
      if (enable) begin
        if (!en_prev) begin
          next_tick = cyc + effp(period);
        end else if (cyc == next_tick) begin
          next_tick = cyc + effp(period);
          if (cyc > busy_until) begin
            if (m_pre > 0) begin
              m_s.e = cyc;
              m_s.d = fq.pop_front();
              sq.push_back(m_s);
              m_pop = 1'b1;
              busy_until = cyc + DVW;
            end else begin
              uq.push_back(cyc);
            end
          end
        end
      end
      if (wr_en) begin
        if (m_pre < DEPTH || m_pop) fq.push_back(wr_data);
        else oq.push_back(cyc);
      end
      en_prev = enable;
    end
  end

  bit      prev_dv = 1'b0;
  int      hi = 0;
  strobe_t s;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_dv = 1'b0;
      hi = 0;
      cur_data = '0;
    end else begin
      checks++;
      if (level !== LW'(fq.size()) || full !== (fq.size() == DEPTH) ||
          empty !== (fq.size() == 0)) begin
        errors++;
        $display("FAIL level @%0d: got level=%0d full=%b empty=%b want level=%0d",
                 cyc, level, full, empty, fq.size());
      end
      if (dv && !prev_dv) begin
        rise_log.push_back(cyc);
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL strobe: unexpected dv rise @%0d data=%h", cyc, tx_data);
        end else begin
          s = sq.pop_front();
          cur_data = s.d;
          if (s.e != cyc || tx_data !== s.d) begin
            errors++;
            $display("FAIL strobe: got cycle=%0d data=%h want cycle=%0d data=%h",
                     cyc, tx_data, s.e, s.d);
          end
        end
        hi = 1;
      end else if (dv) begin
        hi++;
      end else if (prev_dv) begin
        checks++;
        if (hi != DVW) begin
          errors++;
          $display("FAIL dv_width: got %0d want %0d", hi, DVW);
        end
      end
      checks++;
      if (tx_data !== cur_data) begin
        errors++;
        $display("FAIL tx_hold @%0d: got %h want %h", cyc, tx_data, cur_data);
      end
      if (underrun) begin
        ur_count++;
        checks++;
        if (uq.size() == 0 || uq[0] != cyc) begin
          errors++;
          $display("FAIL underrun: unexpected pulse @%0d", cyc);
        end
        if (uq.size() > 0) void'(uq.pop_front());
      end
      if (uq.size() > 0 && uq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL underrun: missing pulse want @%0d", uq[0]);
        void'(uq.pop_front());
      end
      if (overflow) begin
        ov_count++;
        checks++;
        if (oq.size() == 0 || oq[0] != cyc) begin
          errors++;
          $display("FAIL overflow: unexpected pulse @%0d", cyc);
        end
        if (oq.size() > 0) void'(oq.pop_front());
      end
      if (oq.size() > 0 && oq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL overflow: missing pulse want @%0d", oq[0]);
        void'(oq.pop_front());
      end
      if (sq.size() > 0 && sq[0].e < cyc) begin
        checks++; errors++;
        $display("FAIL strobe: missing dv want @%0d data=%h", sq[0].e, sq[0].d);
        void'(sq.pop_front());
      end
      prev_dv = dv;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    wait_n(2);
    reset_n = 1'b1;
    wait_n(1);
  endtask

  task automatic wait_tick_edge(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (enable && en_prev && cyc + 1 == next_tick) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_dv(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (dv) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  int unsigned base;
  logic [DW-1:0] d4;

  initial begin
    wait_n(3);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_tx", 32'(tx_data), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udr", 32'(underrun), 32'd0);
    reset_n = 1'b1;
    wait_n(1);

    push(16'h1234); push(16'hABCD); push(16'h0001);
    rise_log.delete();
    ur_count = 0;
    period = 16'd1000;
    base = cyc;
    enable = 1'b1;
    wait_n(4100);
    chk("t1_count", rise_log.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("t1_rise", (i < rise_log.size()) ? rise_log[i] - base : 0,
          32'(1001 + 1000 * i));
    chk("t1_tx", 32'(tx_data), 32'h0001);
    chk("t1_udr", ur_count, 32'd1);

    enable = 1'b0;
    period = 16'd10;
    wait_n(1);
    for (int i = 0; i < 4; i++) push(DW'($urandom));
    rise_log.delete();
    enable = 1'b1;
    wait_n(576 * 4 + 10);
    chk("t2_count", rise_log.size(), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("t2_gap", (i < rise_log.size()) ? rise_log[i] - rise_log[i-1] : 0, 32'd576);

    enable = 1'b0;
    wait_n(1);
    ov_count = 0;
    for (int i = 0; i < 17; i++) push(DW'($urandom));
    wait_n(2);
    chk("t3_ovf", ov_count, 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    period = 16'd600;
    enable = 1'b1;
    wait_tick_edge("t3_tick_wait");
    push(DW'($urandom));
    wait_n(1);
    chk("t3_level_tick", 32'(level), 32'd16);
    chk("t3_ovf_tick", ov_count, 32'd1);

    do_reset();
    period = 16'd700;
    enable = 1'b1;
    ur_count = 0;
    rise_log.delete();
    wait_tick_edge("t4_tick_wait");
    d4 = DW'($urandom);
    push(d4);
    wait_n(2);
    chk("t4_udr", ur_count, 32'd1);
    chk("t4_nodv", rise_log.size(), 32'd0);
    wait_n(710);
    chk("t4_count", rise_log.size(), 32'd1);
    chk("t4_tx", 32'(tx_data), 32'(d4));

    do_reset();
    for (int i = 0; i < 7; i++) push(DW'($urandom));
    period = 16'd1000;
    rise_log.delete();
    base = cyc;
    enable = 1'b1;
    wait_n(1500);
    period = 16'd2000;
    wait_n(4600);
    chk("t5_count", rise_log.size(), 32'd4);
    chk("t5_first", (rise_log.size() > 0) ? rise_log[0] - base : 0, 32'd1001);
    chk("t5_gap1", (rise_log.size() > 1) ? rise_log[1] - rise_log[0] : 0, 32'd1000);
    chk("t5_gap2", (rise_log.size() > 2) ? rise_log[2] - rise_log[1] : 0, 32'd2000);
    chk("t5_gap3", (rise_log.size() > 3) ? rise_log[3] - rise_log[2] : 0, 32'd2000);
    wait_dv("t5_dv_wait");
    enable = 1'b0;
    wait_n(1);
    chk("t5_dv_hold", 32'(dv), 32'd1);
    wait_n(1);
    chk("t5_dv_end", 32'(dv), 32'd0);
    rise_log.delete();
    wait_n(2500);
    chk("t5_nostrobe", rise_log.size(), 32'd0);
    chk("t5_level", 32'(level), 32'd2);

    do_reset();
    period = 16'(MINP + $urandom_range(0, 300));
    enable = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      wr_en = ($urandom_range(0, 399) == 0) || (i > 6000 && $urandom_range(0, 29) == 0);
      wr_data = DW'($urandom);
      if ($urandom_range(0, 999) == 0) period = 16'($urandom);
      if ($urandom_range(0, 2999) == 0) enable = ~enable;
      @(negedge clk);
    end
    wr_en = 1'b0;

    enable = 1'b0;
    period = 16'd576;
    wait_n(1);
    push(16'h5A5A); push(16'hA5A5);
    enable = 1'b1;
    wait_dv("t6_dv_wait");
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_dv", 32'(dv), 32'd0);
    chk("t6_tx", 32'(tx_data), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    enable = 1'b0;
    wait_n(2);
    reset_n = 1'b1;
    wait_n(5);
    chk("end_sq", sq.size(), 32'd0);
    chk("end_uq", uq.size(), 32'd0);
    chk("end_oq", oq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
